vga_timing_gen: RTL and testbench

- Generates the 640x480@60 Hz raster timing that drives the display path.
- Produces the pixel coordinates x/y consumed by the text and score overlay generators, plus hsync/vsync to the VGA connector.
- Produces the video_on blanking qualifier and a frame-start pulse for score/ball update logic.
- Runs from the 100 MHz board clock, with an internal pixel-tick divider.

---
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-tick divider, x/y counters, registered sync/blank decode.
// Syncs and video_on are decoded from the next counter values so they always match the presented (x,y).
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       f_tick
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HS_START = H_DISP + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_DISP + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  // Counters are 10 bits wide; larger rasters cannot be represented.
  generate
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (CLK_DIV < 2)) begin : g_param_check
      $error("vga_timing_gen: unsupported parameter set");
    end
  endgenerate

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;

  logic             w_p_tick;
  logic             w_x_last;
  logic             w_y_last;
  logic [CNT_W-1:0] w_x_nxt;
  logic [CNT_W-1:0] w_y_nxt;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_von_nxt;

  // Next-state counter values and the decode that rides along with them.
  always_comb begin
    w_p_tick  = (r_div == DIV_W'(CLK_DIV - 1));
    w_x_last  = (r_x == CNT_W'(H_TOTAL - 1));
    w_y_last  = (r_y == CNT_W'(V_TOTAL - 1));
    w_x_nxt   = w_x_last ? '0 : (r_x + CNT_W'(1));
    w_y_nxt   = r_y;
    if (w_x_last) begin
      w_y_nxt = w_y_last ? '0 : (r_y + CNT_W'(1));
    end
    w_hs_act  = (w_x_nxt >= CNT_W'(HS_START)) && (w_x_nxt <= CNT_W'(HS_END));
    w_vs_act  = (w_y_nxt >= CNT_W'(VS_START)) && (w_y_nxt <= CNT_W'(VS_END));
    w_von_nxt = (w_x_nxt < CNT_W'(H_DISP)) && (w_y_nxt < CNT_W'(V_DISP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_hsync    <= ~SYNC_POL;
      r_vsync    <= ~SYNC_POL;
      r_video_on <= 1'b0;
    end else begin
      r_div <= w_p_tick ? '0 : (r_div + DIV_W'(1));
      if (w_p_tick) begin
        r_x        <= w_x_nxt;
        r_y        <= w_y_nxt;
        r_hsync    <= w_hs_act ? SYNC_POL : ~SYNC_POL;
        r_vsync    <= w_vs_act ? SYNC_POL : ~SYNC_POL;
        r_video_on <= w_von_nxt;
      end
    end
  end

  assign x        = r_x;
  assign y        = r_y;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign video_on = r_video_on;
  assign p_tick   = w_p_tick;
  assign f_tick   = w_p_tick && w_x_last && w_y_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance checked with a vector table and a timing model,
// plus a shrunken CLK_DIV=2 / active-high instance exercised with random async resets over many frames.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default 640x480 timing
  logic       rst_a_n;
  logic [9:0] x_a, y_a;
  logic       hs_a, vs_a, von_a, pt_a, ft_a;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .x(x_a), .y(y_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(von_a), .p_tick(pt_a), .f_tick(ft_a)
  );

  // Instance B: tiny raster so whole frames fit in a short run
  localparam int B_CD = 2, B_HD = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VD = 6, B_VF = 2, B_VS = 2, B_VB = 2;
  localparam bit B_POL = 1'b1;

  logic       rst_b_n;
  logic [9:0] x_b, y_b;
  logic       hs_b, vs_b, von_b, pt_b, ft_b;

  vga_timing_gen #(
    .CLK_DIV(B_CD), .H_DISP(B_HD), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_DISP(B_VD), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .SYNC_POL(B_POL)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .x(x_b), .y(y_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .p_tick(pt_b), .f_tick(ft_b)
  );

  int passed = 0;
  int total  = 0;
  int k_a    = 0;
  int k_b    = 0;
  int hs_low = 0;

  typedef struct {
    int x; int y; bit hs; bit vs; bit von; bit pt; bit ft;
  } exp_t;

  typedef struct {
    int k; int x; int y; bit hs; bit vs; bit von; bit pt; bit ft;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Raster position is just (clocks since reset / CLK_DIV) folded into the frame.
  function automatic exp_t model(input int k, input int cd, input int hd, input int hf,
                                 input int hsw, input int hb, input int vd, input int vf,
                                 input int vsw, input int vb, input bit pol);
    exp_t e;
    int ht, vt, ticks, pix;
    ht    = hd + hf + hsw + hb;
    vt    = vd + vf + vsw + vb;
    ticks = k / cd;
    pix   = ticks % (ht * vt);
    e.x   = pix % ht;
    e.y   = pix / ht;
    e.pt  = ((k % cd) == cd - 1);
    e.ft  = e.pt && (e.x == ht - 1) && (e.y == vt - 1);
    if (ticks == 0) begin
      e.hs = ~pol; e.vs = ~pol; e.von = 1'b0;
    end else begin
      e.hs  = (e.x >= hd + hf && e.x < hd + hf + hsw) ? pol : ~pol;
      e.vs  = (e.y >= vd + vf && e.y < vd + vf + vsw) ? pol : ~pol;
      e.von = (e.x < hd) && (e.y < vd);
    end
    return e;
  endfunction

  function automatic exp_t model_a(input int k);
    return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic exp_t model_b(input int k);
    return model(k, B_CD, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, B_POL);
  endfunction

  task automatic chk_out(input string tag, input exp_t e, input logic [9:0] ax, input logic [9:0] ay,
                         input logic ahs, input logic avs, input logic avon, input logic apt,
                         input logic aft);
    chk({tag, ".x"}, int'(ax), e.x);
    chk({tag, ".y"}, int'(ay), e.y);
    chk({tag, ".hsync"}, int'(ahs), int'(e.hs));
    chk({tag, ".vsync"}, int'(avs), int'(e.vs));
    chk({tag, ".video_on"}, int'(avon), int'(e.von));
    chk({tag, ".p_tick"}, int'(apt), int'(e.pt));
    chk({tag, ".f_tick"}, int'(aft), int'(e.ft));
  endtask

  task automatic step_a();
    @(posedge clk); #1; k_a++;
    chk_out($sformatf("A.k%0d", k_a), model_a(k_a), x_a, y_a, hs_a, vs_a, von_a, pt_a, ft_a);
  endtask

  task automatic step_b();
    @(posedge clk); #1; k_b++;
    chk_out($sformatf("B.k%0d", k_b), model_b(k_b), x_b, y_b, hs_b, vs_b, von_b, pt_b, ft_b);
  endtask

  // Walk instance A through the hand-derived table, counting hsync-low clocks on the way.
  task automatic run_vectors(input string pass);
    exp_t e;
    hs_low = 0;
    foreach (vecs[i]) begin
      while (k_a < vecs[i].k) begin
        @(posedge clk); #1; k_a++;
        if (!hs_a) hs_low++;
      end
      e.x = vecs[i].x; e.y = vecs[i].y; e.hs = vecs[i].hs; e.vs = vecs[i].vs;
      e.von = vecs[i].von; e.pt = vecs[i].pt; e.ft = vecs[i].ft;
      chk_out($sformatf("%s.vec_k%0d", pass, vecs[i].k), e, x_a, y_a, hs_a, vs_a, von_a, pt_a, ft_a);
    end
    chk({pass, ".hsync_low_clks"}, hs_low, 384);
  endtask

  task automatic release_a();
    @(negedge clk); rst_a_n = 1'b1; k_a = 0; #1;
  endtask

  task automatic release_b();
    @(negedge clk); rst_b_n = 1'b1; k_b = 0; #1;
    chk_out("B.release", model_b(0), x_b, y_b, hs_b, vs_b, von_b, pt_b, ft_b);
  endtask

  initial begin
    int n, hold, ft_cnt, first_ft, vs_act;
    //          k     x    y  hs vs von pt ft
    vecs.push_back('{0,    0,   0, 1, 1, 0, 0, 0});
    vecs.push_back('{1,    0,   0, 1, 1, 0, 0, 0});
    vecs.push_back('{3,    0,   0, 1, 1, 0, 1, 0});
    vecs.push_back('{4,    1,   0, 1, 1, 1, 0, 0});
    vecs.push_back('{7,    1,   0, 1, 1, 1, 1, 0});
    vecs.push_back('{2559, 639, 0, 1, 1, 1, 1, 0});
    vecs.push_back('{2560, 640, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{2623, 655, 0, 1, 1, 0, 1, 0});
    vecs.push_back('{2624, 656, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{3007, 751, 0, 0, 1, 0, 1, 0});
    vecs.push_back('{3008, 752, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{3197, 799, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{3199, 799, 0, 1, 1, 0, 1, 0});
    vecs.push_back('{3200, 0,   1, 1, 1, 1, 0, 0});
    vecs.push_back('{3203, 0,   1, 1, 1, 1, 1, 0});

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("A.rst.x", int'(x_a), 0);
    chk("A.rst.y", int'(y_a), 0);
    chk("A.rst.hsync", int'(hs_a), 1);
    chk("A.rst.vsync", int'(vs_a), 1);
    chk("A.rst.video_on", int'(von_a), 0);
    chk("A.rst.p_tick", int'(pt_a), 0);
    chk("A.rst.f_tick", int'(ft_a), 0);

    release_a();
    run_vectors("A1");

    // Continue to (700,1) against the model, then reset mid-cycle with hsync active.
    while (k_a < 6001) step_a();
    #2;
    chk("A.pre_rst.x", int'(x_a), 700);
    chk("A.pre_rst.hsync", int'(hs_a), 0);
    rst_a_n = 1'b0;
    #1;
    chk("A.async_rst.x", int'(x_a), 0);
    chk("A.async_rst.y", int'(y_a), 0);
    chk("A.async_rst.hsync", int'(hs_a), 1);
    chk("A.async_rst.video_on", int'(von_a), 0);
    chk("A.async_rst.f_tick", int'(ft_a), 0);
    hold = $urandom_range(2, 9);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("A.rst_hold.p_tick", int'(pt_a), 0);
      chk("A.rst_hold.f_tick", int'(ft_a), 0);
    end
    release_a();
    run_vectors("A2");

    // Instance B: random run lengths broken by random asynchronous resets.
    release_b();
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(20, 900);
      repeat (n) step_b();
      #($urandom_range(1, 3));
      rst_b_n = 1'b0;
      #1;
      chk("B.async_rst.x", int'(x_b), 0);
      chk("B.async_rst.y", int'(y_b), 0);
      chk("B.async_rst.hsync", int'(hs_b), 0);
      chk("B.async_rst.vsync", int'(vs_b), 0);
      chk("B.async_rst.video_on", int'(von_b), 0);
      chk("B.async_rst.f_tick", int'(ft_b), 0);
      hold = $urandom_range(1, 5);
      repeat (hold) begin
        @(posedge clk); #1;
        chk("B.rst_hold.f_tick", int'(ft_b), 0);
      end
      release_b();
    end

    // Two clean frames from reset: frame length, f_tick count and vsync width.
    ft_cnt = 0; first_ft = -1; vs_act = 0;
    repeat (720) begin
      step_b();
      if (ft_b) begin
        ft_cnt++;
        if (first_ft < 0) first_ft = k_b;
      end
      if (vs_b == B_POL) vs_act++;
    end
    chk("B.f_tick_count", ft_cnt, 2);
    chk("B.first_f_tick_k", first_ft, 359);
    chk("B.vsync_active_clks", vs_act, 120);
    step_b();
    chk("B.after_wrap.x", int'(x_b), 0);
    chk("B.after_wrap.y", int'(y_b), 0);
    chk("B.after_wrap.video_on", int'(von_b), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
